// File: rtl/bcd_digit_entry_if.sv
// Keypad-side bundle for the decimal digit entry block: digit/command
// strobes toward the block, committed value and status back out.
interface bcd_digit_entry_if #(
    parameter int OUT_W = 7
);
    logic [3:0]       digit_in;
    logic             digit_valid;
    logic             enter;
    logic             clear;
    logic [OUT_W-1:0] value_out;
    logic             value_valid;
    logic [3:0]       digit_count;
    logic             full;
    logic             err;

    // Front end (keypad scanner or testbench) drives the strobes.
    modport master (
        output digit_in, digit_valid, enter, clear,
        input  value_out, value_valid, digit_count, full, err
    );

    // Entry block consumes strobes and reports the committed value.
    modport slave (
        input  digit_in, digit_valid, enter, clear,
        output value_out, value_valid, digit_count, full, err
    );
endinterface

// File: rtl/bcd_digit_entry.sv
// Sequential decimal-to-binary entry: BCD digits arrive MSD first, are
// folded into a binary accumulator (acc*10 + digit) and committed to
// value_out on enter. Invalid digits latch a sticky error that only
// clear removes.
module bcd_digit_entry #(
    parameter int OUT_W      = 7,
    parameter int MAX_DIGITS = 2
) (
    input logic             clk,
    input logic             rst_n,
    bcd_digit_entry_if.slave bus
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    // The accumulator must hold the largest MAX_DIGITS-digit number.
    generate
        if (MAX_DIGITS < 1 || MAX_DIGITS > 15) begin : g_bad_digits
            $error("bcd_digit_entry: MAX_DIGITS must be in 1..15");
        end
        if (OUT_W < 64) begin : g_width_chk
            if ((64'd1 << OUT_W) <= (pow10(MAX_DIGITS) - 64'd1)) begin : g_bad_width
                $error("bcd_digit_entry: OUT_W too narrow for MAX_DIGITS");
            end
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    state_t           r_state,       w_state_next;
    logic [OUT_W-1:0] r_acc,         w_acc_next;
    logic [OUT_W-1:0] r_value_out,   w_value_out_next;
    logic             r_value_valid, w_value_valid_next;
    logic [3:0]       r_digit_count, w_digit_count_next;
    logic             r_err,         w_err_next;

    logic             w_full;
    logic             w_digit_ok;
    logic [OUT_W-1:0] w_acc_times10_plus;

    assign w_full     = (r_digit_count == MAX_CNT);
    assign w_digit_ok = (bus.digit_in <= 4'd9);
    // Shift-add multiply by ten; width sizing guarantees no overflow.
    assign w_acc_times10_plus = (r_acc << 3) + (r_acc << 1) + OUT_W'(bus.digit_in);

    // State and datapath registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= EMPTY;
            r_acc         <= '0;
            r_value_out   <= '0;
            r_value_valid <= 1'b0;
            r_digit_count <= 4'd0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_acc         <= w_acc_next;
            r_value_out   <= w_value_out_next;
            r_value_valid <= w_value_valid_next;
            r_digit_count <= w_digit_count_next;
            r_err         <= w_err_next;
        end
    end

    // Next-state decode; clear beats enter beats digit_valid, and a
    // higher-priority strobe swallows the lower ones in the same cycle.
    always_comb begin
        w_state_next       = r_state;
        w_acc_next         = r_acc;
        w_value_out_next   = r_value_out;
        w_value_valid_next = r_value_valid;
        w_digit_count_next = r_digit_count;
        w_err_next         = r_err;

        if (bus.clear) begin
            w_state_next       = EMPTY;
            w_acc_next         = '0;
            w_value_out_next   = '0;
            w_value_valid_next = 1'b0;
            w_digit_count_next = 4'd0;
            w_err_next         = 1'b0;
        end else if (bus.enter) begin
            if (r_state == ENTRY) begin
                w_state_next       = HOLD;
                w_value_out_next   = r_acc;
                w_value_valid_next = 1'b1;
                w_acc_next         = '0;
                w_digit_count_next = 4'd0;
            end
        end else if (bus.digit_valid && (r_state != ERROR)) begin
            if (!w_digit_ok) begin
                w_state_next       = ERROR;
                w_err_next         = 1'b1;
                w_value_valid_next = 1'b0;
                w_acc_next         = '0;
                w_digit_count_next = 4'd0;
            end else begin
                case (r_state)
                    EMPTY, HOLD: begin
                        // First digit of a new entry; old value_out stays visible.
                        w_state_next       = ENTRY;
                        w_acc_next         = OUT_W'(bus.digit_in);
                        w_digit_count_next = 4'd1;
                        w_value_valid_next = 1'b0;
                    end
                    ENTRY: begin
                        // Digits beyond MAX_DIGITS are silently dropped.
                        if (!w_full) begin
                            w_acc_next         = w_acc_times10_plus;
                            w_digit_count_next = r_digit_count + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.value_out   = r_value_out;
    assign bus.value_valid = r_value_valid;
    assign bus.digit_count = r_digit_count;
    assign bus.full        = w_full;
    assign bus.err         = r_err;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Bench for bcd_digit_entry: directed scenarios followed by a randomized
// run checked against a numeric model of decimal entry.
module tb_bcd_digit_entry;

    localparam int OUT_W      = 7;
    localparam int MAX_DIGITS = 2;

    logic clk;
    logic rst_n;

    bcd_digit_entry_if #(.OUT_W(OUT_W)) bus ();

    bcd_digit_entry #(.OUT_W(OUT_W), .MAX_DIGITS(MAX_DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: a number being typed in, plus a committed value.
    int m_acc;
    int m_cnt;
    int m_vo;
    bit m_vv;
    bit m_err;

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_vo = 0; m_vv = 0; m_err = 0;
    endtask

    task automatic model_apply(input bit dv, input int d, input bit en, input bit clr);
        if (clr) begin
            model_reset();
        end else if (en) begin
            if (!m_err && m_cnt > 0) begin
                m_vo = m_acc; m_vv = 1; m_acc = 0; m_cnt = 0;
            end
        end else if (dv && !m_err) begin
            if (d > 9) begin
                m_err = 1; m_vv = 0; m_acc = 0; m_cnt = 0;
            end else if (m_cnt == 0) begin
                m_acc = d; m_cnt = 1; m_vv = 0;
            end else if (m_cnt < MAX_DIGITS) begin
                m_acc = m_acc * 10 + d; m_cnt = m_cnt + 1;
            end
        end
    endtask

    // Present one cycle of strobes, then sample #1 after the edge.
    task automatic step(input bit dv, input logic [3:0] d, input bit en, input bit clr);
        bus.digit_valid = dv;
        bus.digit_in    = d;
        bus.enter       = en;
        bus.clear       = clr;
        @(posedge clk);
        #1;
        bus.digit_valid = 1'b0;
        bus.enter       = 1'b0;
        bus.clear       = 1'b0;
        model_apply(dv, int'(d), en, clr);
        $display("t=%0t dv=%0b d=%0d en=%0b clr=%0b -> vo=%0d vv=%0b cnt=%0d full=%0b err=%0b",
                 $time, dv, d, en, clr, bus.value_out, bus.value_valid,
                 bus.digit_count, bus.full, bus.err);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.digit_in = 4'd0; bus.digit_valid = 1'b0; bus.enter = 1'b0; bus.clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.value_out !== 7'd0) begin n_err++; $display("FAIL reset_vo got %0d want 0", bus.value_out); end
        n_vec++; if (bus.value_valid !== 1'b0) begin n_err++; $display("FAIL reset_vv got %0b want 0", bus.value_valid); end
        n_vec++; if (bus.digit_count !== 4'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", bus.digit_count); end
        n_vec++; if (bus.full !== 1'b0 || bus.err !== 1'b0) begin n_err++; $display("FAIL reset_flags got full=%0b err=%0b want 0 0", bus.full, bus.err); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        step(1, 4'd4, 0, 0);
        n_vec++; if (bus.digit_count !== 4'd1 || bus.full !== 1'b0) begin n_err++; $display("FAIL basic_d1 got cnt=%0d full=%0b want 1 0", bus.digit_count, bus.full); end
        step(1, 4'd2, 0, 0);
        n_vec++; if (bus.digit_count !== 4'd2 || bus.full !== 1'b1) begin n_err++; $display("FAIL basic_d2 got cnt=%0d full=%0b want 2 1", bus.digit_count, bus.full); end
        step(0, 4'd0, 1, 0);
        n_vec++; if (bus.value_out !== 7'd42 || bus.value_valid !== 1'b1) begin n_err++; $display("FAIL basic_enter got vo=%0d vv=%0b want 42 1", bus.value_out, bus.value_valid); end
        n_vec++; if (bus.digit_count !== 4'd0) begin n_err++; $display("FAIL basic_cnt got %0d want 0", bus.digit_count); end
    endtask

    task automatic test_hold_redigit();
        step(1, 4'd9, 0, 0);
        n_vec++; if (bus.value_valid !== 1'b0 || bus.value_out !== 7'd42 || bus.digit_count !== 4'd1) begin n_err++; $display("FAIL redigit got vv=%0b vo=%0d cnt=%0d want 0 42 1", bus.value_valid, bus.value_out, bus.digit_count); end
        step(0, 4'd0, 1, 0);
        n_vec++; if (bus.value_out !== 7'd9 || bus.value_valid !== 1'b1) begin n_err++; $display("FAIL redigit_enter got vo=%0d vv=%0b want 9 1", bus.value_out, bus.value_valid); end
    endtask

    task automatic test_overflow_drop();
        step(1, 4'd9, 0, 0);
        step(1, 4'd9, 0, 0);
        step(1, 4'd5, 0, 0);
        n_vec++; if (bus.digit_count !== 4'd2 || bus.full !== 1'b1 || bus.err !== 1'b0) begin n_err++; $display("FAIL drop got cnt=%0d full=%0b err=%0b want 2 1 0", bus.digit_count, bus.full, bus.err); end
        step(0, 4'd0, 1, 0);
        n_vec++; if (bus.value_out !== 7'd99) begin n_err++; $display("FAIL drop_vo got %0d want 99", bus.value_out); end
        step(0, 4'd0, 1, 0);
        n_vec++; if (bus.value_out !== 7'd99 || bus.value_valid !== 1'b1) begin n_err++; $display("FAIL hold_enter got vo=%0d vv=%0b want 99 1", bus.value_out, bus.value_valid); end
        step(0, 4'd0, 0, 1);
        step(0, 4'd0, 1, 0);
        n_vec++; if (bus.value_out !== 7'd0 || bus.value_valid !== 1'b0) begin n_err++; $display("FAIL empty_enter got vo=%0d vv=%0b want 0 0", bus.value_out, bus.value_valid); end
    endtask

    task automatic test_error();
        step(1, 4'd3, 0, 0);
        step(1, 4'hC, 0, 0);
        n_vec++; if (bus.err !== 1'b1 || bus.value_valid !== 1'b0 || bus.digit_count !== 4'd0) begin n_err++; $display("FAIL err_set got err=%0b vv=%0b cnt=%0d want 1 0 0", bus.err, bus.value_valid, bus.digit_count); end
        step(1, 4'd1, 0, 0);
        step(0, 4'd0, 1, 0);
        n_vec++; if (bus.err !== 1'b1 || bus.value_valid !== 1'b0 || bus.digit_count !== 4'd0) begin n_err++; $display("FAIL err_sticky got err=%0b vv=%0b cnt=%0d want 1 0 0", bus.err, bus.value_valid, bus.digit_count); end
        step(0, 4'd0, 0, 1);
        n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL err_clear got %0b want 0", bus.err); end
        step(1, 4'd1, 0, 0);
        step(0, 4'd0, 1, 0);
        n_vec++; if (bus.value_out !== 7'd1 || bus.value_valid !== 1'b1) begin n_err++; $display("FAIL err_recover got vo=%0d vv=%0b want 1 1", bus.value_out, bus.value_valid); end
    endtask

    task automatic test_simultaneous();
        step(1, 4'd5, 0, 0);
        step(0, 4'd0, 1, 1);
        n_vec++; if (bus.value_valid !== 1'b0 || bus.value_out !== 7'd0 || bus.digit_count !== 4'd0) begin n_err++; $display("FAIL clr_enter got vv=%0b vo=%0d cnt=%0d want 0 0 0", bus.value_valid, bus.value_out, bus.digit_count); end
        step(1, 4'd5, 0, 0);
        step(1, 4'd7, 1, 0);
        n_vec++; if (bus.value_out !== 7'd5 || bus.value_valid !== 1'b1 || bus.digit_count !== 4'd0) begin n_err++; $display("FAIL enter_digit got vo=%0d vv=%0b cnt=%0d want 5 1 0", bus.value_out, bus.value_valid, bus.digit_count); end
    endtask

    task automatic test_async_reset();
        step(1, 4'd8, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++; if (bus.digit_count !== 4'd0 || bus.value_out !== 7'd0 || bus.value_valid !== 1'b0 || bus.err !== 1'b0 || bus.full !== 1'b0) begin n_err++; $display("FAIL async_rst got cnt=%0d vo=%0d vv=%0b err=%0b full=%0b want all 0", bus.digit_count, bus.value_out, bus.value_valid, bus.err, bus.full); end
        #2;
        rst_n = 1'b1;
        step(1, 4'd6, 0, 0);
        step(0, 4'd0, 1, 0);
        n_vec++; if (bus.value_out !== 7'd6 || bus.value_valid !== 1'b1) begin n_err++; $display("FAIL after_rst got vo=%0d vv=%0b want 6 1", bus.value_out, bus.value_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit         dv, en, clr;
            logic [3:0] d;
            clr = ($urandom_range(0, 99) < 4);
            en  = ($urandom_range(0, 99) < 20);
            dv  = ($urandom_range(0, 99) < 65);
            d   = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            step(dv, d, en, clr);
            n_vec++; if (bus.value_out !== OUT_W'(m_vo)) begin n_err++; $display("FAIL rnd_vo[%0d] got %0d want %0d", i, bus.value_out, m_vo); end
            n_vec++; if (bus.value_valid !== m_vv) begin n_err++; $display("FAIL rnd_vv[%0d] got %0b want %0b", i, bus.value_valid, m_vv); end
            n_vec++; if (bus.digit_count !== 4'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, bus.digit_count, m_cnt); end
            n_vec++; if (bus.full !== (m_cnt == MAX_DIGITS)) begin n_err++; $display("FAIL rnd_full[%0d] got %0b want %0b", i, bus.full, (m_cnt == MAX_DIGITS)); end
            n_vec++; if (bus.err !== m_err) begin n_err++; $display("FAIL rnd_err[%0d] got %0b want %0b", i, bus.err, m_err); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_hold_redigit();
        test_overflow_drop();
        test_error();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
